// File: rtl/dfi_init_seq.sv
// DFI init handshake sequencer: optional start delay, start/ack/complete handshake
// with the PHY, timeout detection, sticky status and a one-cycle completion irq.
module dfi_init_seq #(
  parameter logic AUTO_START = 1'b0,
  parameter int   CNT_W      = 16,
  parameter int   START_DLY  = 16,
  parameter int   TIMEOUT    = 65535
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sw_start_i,
  input  logic             sw_abort_i,
  input  logic             dfi_init_complete_i,
  output logic             dfi_init_start_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic             irq_o,
  output logic [CNT_W-1:0] cycles_o
);

  // state    | meaning
  // IDLE     | waiting for a software start
  // DELAY    | counting START_DLY cycles before requesting init
  // WAIT_ACK | start asserted, waiting for the PHY to drop complete
  // WAIT_CMP | start asserted, waiting for the PHY to raise complete
  // DONE     | last sequence completed
  // ERR      | last sequence timed out
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DELAY    = 3'd1;
  localparam logic [2:0] S_WAIT_ACK = 3'd2;
  localparam logic [2:0] S_WAIT_CMP = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam logic [2:0] S_ERR      = 3'd5;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'((START_DLY > 0) ? START_DLY - 1 : 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic             DLY_ZERO = (START_DLY == 0);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             comp_q;
  logic             start_q, busy_q, irq_q;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             irq_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cycles_d  = cycles_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    irq_d     = 1'b0;
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    if (sw_abort_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (sw_start_i) begin
            state_d   = DLY_ZERO ? S_WAIT_ACK : S_DELAY;
            cnt_d     = '0;
            done_d    = 1'b0;
            timeout_d = 1'b0;
          end
        end
        S_DELAY: begin
          if (DLY_ZERO || cnt_q == DLY_LAST) begin
            state_d = S_WAIT_ACK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_WAIT_ACK: begin
          if (!comp_q) begin
            state_d = S_WAIT_CMP;
            cnt_d   = cnt_inc;
          end else if (cnt_q == TMO_LAST) begin
            state_d   = S_ERR;
            timeout_d = 1'b1;
            irq_d     = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_WAIT_CMP: begin
          // completion seen on the last allowed cycle still counts as success
          if (comp_q) begin
            state_d  = S_DONE;
            cycles_d = cnt_q;
            done_d   = 1'b1;
            irq_d    = 1'b1;
          end else if (cnt_q == TMO_LAST) begin
            state_d   = S_ERR;
            timeout_d = 1'b1;
            irq_d     = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= AUTO_START ? S_DELAY : S_IDLE;
      cnt_q     <= '0;
      cycles_q  <= '0;
      comp_q    <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cycles_q  <= cycles_d;
      comp_q    <= dfi_init_complete_i;
      start_q   <= (state_d == S_WAIT_ACK) || (state_d == S_WAIT_CMP);
      busy_q    <= (state_d == S_DELAY) || (state_d == S_WAIT_ACK) || (state_d == S_WAIT_CMP);
      done_q    <= done_d;
      timeout_q <= timeout_d;
      irq_q     <= irq_d;
    end
  end

  assign dfi_init_start_o = start_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign timeout_o        = timeout_q;
  assign irq_o            = irq_q;
  assign cycles_o         = cycles_q;

endmodule

// File: tb/tb_dfi_init_seq.sv
// Bench for dfi_init_seq: two instances (manual and auto start) driven by directed
// scenarios and random stimulus, compared every cycle with a phase-level model.
module tb_dfi_init_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sw_start, sw_abort, phy_cmp;
  logic m_start, m_busy, m_done, m_tmo, m_irq;
  logic a_start, a_busy, a_done, a_tmo, a_irq;
  logic [W-1:0] m_cycles, a_cycles;

  dfi_init_seq #(.AUTO_START(1'b0), .CNT_W(W), .START_DLY(4), .TIMEOUT(20)) u_dut (
    .clk_i(clk), .rst_i(rst), .sw_start_i(sw_start), .sw_abort_i(sw_abort),
    .dfi_init_complete_i(phy_cmp), .dfi_init_start_o(m_start), .busy_o(m_busy),
    .done_o(m_done), .timeout_o(m_tmo), .irq_o(m_irq), .cycles_o(m_cycles));

  dfi_init_seq #(.AUTO_START(1'b1), .CNT_W(W), .START_DLY(0), .TIMEOUT(12)) u_auto (
    .clk_i(clk), .rst_i(rst), .sw_start_i(sw_start), .sw_abort_i(sw_abort),
    .dfi_init_complete_i(phy_cmp), .dfi_init_start_o(a_start), .busy_o(a_busy),
    .done_o(a_done), .timeout_o(a_tmo), .irq_o(a_irq), .cycles_o(a_cycles));

  typedef enum {P_IDLE, P_DLY, P_ACK, P_CMP, P_OK, P_TO} phase_t;
  typedef struct {
    phase_t ph;
    int     el;
    bit     comp, busy, done, to, irq;
    int     cycles;
  } mdl_t;

  mdl_t mm, ma;
  int   n_chk = 0, n_fail = 0;
  int   irq_m = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit drives_start(mdl_t s);
    return s.ph == P_ACK || s.ph == P_CMP;
  endfunction

  // one clock of the sequence described in phase terms
  function automatic mdl_t step(mdl_t s, bit auto_st, int dly, int tmo, bit r, bit st, bit ab, bit cin);
    mdl_t n = s;
    bit   fin;
    n.irq = 0;
    if (r) begin
      n.ph = auto_st ? P_DLY : P_IDLE;
      n.el = 0; n.comp = 0; n.busy = 0; n.done = 0; n.to = 0; n.cycles = 0;
      return n;
    end
    n.comp = cin;
    if (ab) begin
      n.ph = P_IDLE;
      n.el = 0;
    end else begin
      case (s.ph)
        P_IDLE, P_OK, P_TO:
          if (st) begin
            n.done = 0; n.to = 0; n.el = 0;
            n.ph = (dly == 0) ? P_ACK : P_DLY;
          end
        P_DLY:
          if (s.el + 1 >= dly) begin n.ph = P_ACK; n.el = 0; end
          else n.el = s.el + 1;
        default: begin
          fin = (s.ph == P_ACK) ? !s.comp : s.comp;
          if (fin && s.ph == P_CMP) begin
            n.ph = P_OK; n.done = 1; n.irq = 1; n.cycles = s.el;
          end else if (fin) begin
            n.ph = P_CMP; n.el = s.el + 1;
          end else if (s.el == tmo - 1) begin
            n.ph = P_TO; n.to = 1; n.irq = 1;
          end else begin
            n.el = s.el + 1;
          end
        end
      endcase
    end
    n.busy = (n.ph == P_DLY) || (n.ph == P_ACK) || (n.ph == P_CMP);
    return n;
  endfunction

  task automatic tick(input bit r, input bit st, input bit ab, input bit cin);
    rst = r; sw_start = st; sw_abort = ab; phy_cmp = cin;
    @(posedge clk);
    mm = step(mm, 1'b0, 4, 20, r, st, ab, cin);
    ma = step(ma, 1'b1, 0, 12, r, st, ab, cin);
    #1;
    if (m_irq === 1'b1) irq_m++;
    check("m_start",  m_start,  drives_start(mm));
    check("m_busy",   m_busy,   mm.busy);
    check("m_done",   m_done,   mm.done);
    check("m_tmo",    m_tmo,    mm.to);
    check("m_irq",    m_irq,    mm.irq);
    check("m_cycles", m_cycles, mm.cycles);
    check("a_start",  a_start,  drives_start(ma));
    check("a_busy",   a_busy,   ma.busy);
    check("a_done",   a_done,   ma.done);
    check("a_tmo",    a_tmo,    ma.to);
    check("a_irq",    a_irq,    ma.irq);
    check("a_cycles", a_cycles, ma.cycles);
  endtask

  initial begin
    int k, hi, n;
    bit cin;
    rst = 1'b1; sw_start = 1'b0; sw_abort = 1'b0; phy_cmp = 1'b1;
    mm = '{ph: P_IDLE, el: 0, comp: 0, busy: 0, done: 0, to: 0, irq: 0, cycles: 0};
    ma = mm;

    tick(1, 0, 0, 1); tick(1, 0, 0, 1);
    check("rst_start", m_start, 0);
    check("rst_busy_auto", a_busy, 0);
    for (int i = 0; i < 30; i++) tick(0, 0, 0, 1);

    // 1: normal handshake, complete drops 3 cycles into start, rises 10 later
    irq_m = 0; k = 0; n = 0;
    tick(0, 1, 0, 1); n = 1;
    while (!m_start && n < 20) begin tick(0, 0, 0, 1); n++; end
    check("t1_dly", n, 5);
    for (int i = 0; i < 40 && mm.ph != P_OK; i++) begin
      k++;
      tick(0, 0, 0, !(k >= 3 && k < 13));
    end
    check("t1_done", m_done, 1);
    check("t1_cycles", m_cycles, 13);
    tick(0, 0, 0, 1);
    check("t1_start_off", m_start, 0);
    check("t1_irq_cnt", irq_m, 1);

    // 2: PHY never acknowledges
    irq_m = 0; hi = 0;
    tick(0, 1, 0, 1);
    for (int i = 0; i < 40; i++) begin tick(0, 0, 0, 1); if (m_start) hi++; end
    check("t2_start_len", hi, 20);
    check("t2_tmo", m_tmo, 1);
    check("t2_done", m_done, 0);
    check("t2_irq_cnt", irq_m, 1);

    // 3: completion arrives on the last allowed cycle
    tick(0, 1, 0, 1);
    for (int i = 0; i < 60 && mm.ph != P_OK && mm.ph != P_TO; i++) begin
      cin = !(mm.ph == P_ACK || (mm.ph == P_CMP && mm.el < 18));
      tick(0, 0, 0, cin);
    end
    check("t3_done", m_done, 1);
    check("t3_tmo", m_tmo, 0);
    check("t3_cycles", m_cycles, 19);

    // 4: abort during WAIT_CMP, then a fresh run
    irq_m = 0;
    tick(0, 1, 0, 1);
    for (int i = 0; i < 20 && mm.ph != P_CMP; i++) tick(0, 0, 0, mm.ph != P_ACK);
    tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    tick(0, 0, 1, 0);
    check("t4_abort_start", m_start, 0);
    check("t4_abort_busy", m_busy, 0);
    tick(0, 0, 0, 1);
    check("t4_abort_irq", irq_m, 0);
    tick(0, 1, 0, 1);
    for (int i = 0; i < 40 && mm.ph != P_OK; i++) tick(0, 0, 0, mm.ph != P_ACK);
    check("t4_rerun_done", m_done, 1);

    // 6: start pulses mid-sequence are ignored, a pulse in DONE restarts
    tick(0, 1, 0, 1); n = 1;
    tick(0, 0, 0, 1); tick(0, 1, 0, 1); n = 3;
    while (!m_start && n < 20) begin tick(0, 0, 0, 1); n++; end
    check("t6_dly", n, 5);
    tick(0, 1, 0, 1);
    for (int i = 0; i < 40 && mm.ph != P_OK; i++) tick(0, 0, 0, mm.ph != P_ACK);
    check("t6_done", m_done, 1);
    tick(0, 1, 0, 1);
    check("t6_restart_done", m_done, 0);
    check("t6_restart_busy", m_busy, 1);
    for (int i = 0; i < 40; i++) tick(0, 0, 0, 1);

    // 5: auto start out of reset, reset mid WAIT_CMP
    tick(1, 0, 0, 1); tick(1, 0, 0, 1);
    tick(0, 0, 0, 1);
    check("t5_auto_start", a_start, 1);
    tick(0, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    check("t5_in_cmp_busy", a_busy, 1);
    tick(1, 0, 0, 0);
    check("t5_rst_start", a_start, 0);
    tick(0, 0, 0, 1);
    check("t5_rerun_start", a_start, 1);

    // random traffic against the model
    cin = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) cin = !cin;
      tick($urandom_range(0, 499) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 59) == 0, cin);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
